router_fifo_n: RTL

//   Parametrised, buffered successor to the 1-to-4 combinational router.
//   - Routes input words by addr to NUM_PORTS output ports, each with its own FIFO.
//   - Uses a valid/ready handshake on every port.
//   - Drops and counts words with an out-of-range address.
//   - Sits between a single producer and NUM_PORTS independent consumers.

---
 rtl/router_fifo_n.sv | 131 +++++++++++++
 1 files changed

// File: rtl/router_fifo_n.sv
// -----------------------------------------------------------------------------
// router_fifo_n
//   Buffered 1-to-NUM_PORTS word router. Each input word is steered by addr
//   into a per-port show-ahead FIFO. Every port uses a valid/ready handshake.
//   Words whose address has no matching port are accepted, discarded and
//   counted in a saturating error counter.
//
// Ports
//   clk        in   1                     rising-edge clock
//   rst_n      in   1                     synchronous active-low reset
//   data_in    in   DATA_WIDTH            input word
//   data_en    in   1                     input valid
//   addr       in   ADDR_WIDTH            destination port index
//   data_rdy   out  1                     input ready (combinational on addr)
//   data_out   out  NUM_PORTS*DATA_WIDTH  port p head word at [p*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out  NUM_PORTS             port p FIFO non-empty
//   out_ready  in   NUM_PORTS             port p consumer accepts head word
//   err_cnt    out  ERR_WIDTH             saturating count of bad-address words
// -----------------------------------------------------------------------------
module router_fifo_n #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = $clog2(NUM_PORTS),
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            data_en,
  input  logic [ADDR_WIDTH-1:0]           addr,
  output logic                            data_rdy,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
  output logic [NUM_PORTS-1:0]            out_valid,
  input  logic [NUM_PORTS-1:0]            out_ready,
  output logic [ERR_WIDTH-1:0]            err_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Input side: address decode and acceptance
  // ---------------------------------------------------------------------------
  logic                 w_addr_ok;   // addr names an existing port
  logic                 w_tgt_full;  // target port FIFO is full
  logic                 w_accept;    // word taken at the next posedge
  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_push;
  logic [NUM_PORTS-1:0] w_pop;

  // Widen addr before comparing so the test stays meaningful when
  // NUM_PORTS is not a power of two and out-of-range codes exist.
  assign w_addr_ok = (int'(addr) < NUM_PORTS);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_tgt_full = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (int'(addr) == p) w_tgt_full = w_full[p];
    end
  end

  // A bad address is always ready (it is dropped); a good one waits for
  // room in its own FIFO. A pop on the same edge does not free space.
  assign data_rdy = rst_n && (!w_addr_ok || !w_tgt_full);
  assign w_accept = data_en && data_rdy;

  // ---------------------------------------------------------------------------
  // Per-port show-ahead FIFOs
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_valid;

    assign w_valid   = (r_count != '0);
    assign w_full[g] = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push[g] = w_accept && w_addr_ok && (int'(addr) == g);
    // Pop requires a non-empty FIFO, so out_ready on an empty port is inert
    // and push/pop on an empty port in one cycle cannot happen.
    assign w_pop[g]  = w_valid && out_ready[g];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement or block order.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[g]) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop[g])  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        // Simultaneous push and pop leaves the occupancy unchanged.
        unique case ({w_push[g], w_pop[g]})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    // NOTE: the storage array has no reset; stale entries are unreachable
    // because out_valid and the output mask below are driven from r_count.
    always_ff @(posedge clk) begin
      if (w_push[g]) r_mem[r_wr_ptr] <= data_in;
    end

    assign out_valid[g]                          = w_valid;
    assign data_out[g*DATA_WIDTH +: DATA_WIDTH] = w_valid ? r_mem[r_rd_ptr] : '0;
  end

  // ---------------------------------------------------------------------------
  // Saturating dropped-word counter
  // ---------------------------------------------------------------------------
  logic [ERR_WIDTH-1:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_accept && !w_addr_ok && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_WIDTH'(1);
    end
  end

  assign err_cnt = r_err_cnt;

endmodule
